// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline-stage register with flush and saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer and register ReadyD.
module pipe_stage_hs #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ValidD,
  input  logic [WIDTH-1:0] DataD,
  output logic             ReadyD,
  output logic             ValidE,
  output logic [WIDTH-1:0] DataE,
  input  logic             ReadyE,
  input  logic             Flush,
  output logic [CNT_W-1:0] StallCount
);

  logic             valid_e_q, valid_e_d;
  logic [WIDTH-1:0] data_e_q,  data_e_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             ready_d;
  logic             accept;

  assign accept = ValidD & ready_d;

`ifdef PIPE_STAGE_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             xfer;

  assign xfer    = valid_e_q & ReadyE;
  assign ready_d = ~skid_valid_q;

  // {valid_e, skid_valid}: 00 EMPTY, 10 ONE, 11 FULL; 01 is unreachable and recovers as EMPTY.
  always_comb begin
    valid_e_d    = valid_e_q;
    data_e_d     = data_e_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (Flush) begin
      valid_e_d    = 1'b0;
      data_e_d     = '0;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
    end else begin
      unique case ({valid_e_q, skid_valid_q})
        2'b10: begin
          if (xfer && accept) begin
            data_e_d = DataD;
          end else if (xfer) begin
            valid_e_d = 1'b0;
            data_e_d  = '0;
          end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = DataD;
          end
        end
        2'b11: begin
          if (xfer) begin
            data_e_d     = skid_data_q;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
          end
        end
        default: begin
          valid_e_d    = accept;
          data_e_d     = accept ? DataD : '0;
          skid_valid_d = 1'b0;
          skid_data_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  assign ready_d = ~valid_e_q | ReadyE;

  always_comb begin
    valid_e_d = valid_e_q;
    data_e_d  = data_e_q;
    if (Flush) begin
      valid_e_d = 1'b0;
      data_e_d  = '0;
    end else if (ready_d) begin
      valid_e_d = ValidD;
      data_e_d  = accept ? DataD : '0;
    end
  end
`endif

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_e_q && !ReadyE && !Flush && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      valid_e_q   <= 1'b0;
      data_e_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_e_q   <= valid_e_d;
      data_e_q    <= data_e_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ReadyD     = ready_d;
  assign ValidE     = valid_e_q;
  assign DataE      = data_e_q;
  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed scoreboard bench for pipe_stage_hs; a second instance with CNT_W=3 covers saturation.
module tb_pipe_stage_hs;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        ValidD;
  logic [31:0] DataD;
  logic        ReadyD;
  logic        ValidE;
  logic [31:0] DataE;
  logic        ReadyE;
  logic        Flush;
  logic [15:0] StallCount;

  logic        s_ReadyD, s_ValidE;
  logic [31:0] s_DataE;
  logic [2:0]  s_StallCount;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] q[$];
  int          stall_exp = 0;
  int          stall_small_exp = 0;

  pipe_stage_hs #(.WIDTH(32), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .ValidD(ValidD), .DataD(DataD), .ReadyD(ReadyD),
    .ValidE(ValidE), .DataE(DataE), .ReadyE(ReadyE), .Flush(Flush),
    .StallCount(StallCount)
  );

  pipe_stage_hs #(.WIDTH(32), .CNT_W(3)) dut_small (
    .Clk(Clk), .Rst(Rst), .ValidD(ValidD), .DataD(DataD), .ReadyD(s_ReadyD),
    .ValidE(s_ValidE), .DataE(s_DataE), .ReadyE(ReadyE), .Flush(Flush),
    .StallCount(s_StallCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks outputs against the scoreboard, then advances one clock edge and updates the model.
  task automatic tick();
    logic acc, xfer, inc;
    logic [31:0] exp_v;
    chk("valid_e", ValidE, q.size() > 0);
    if (q.size() > 0) chk("data_e", DataE, q[0]);
    else              chk("bubble_zero", DataE, 0);
    chk("stall_cnt", StallCount, stall_exp);
    chk("stall_cnt_small", s_StallCount, stall_small_exp);
    acc  = ValidD && ReadyD;
    xfer = ValidE && ReadyE;
    inc  = (q.size() > 0) && !ReadyE && !Flush;
    if (xfer) begin
      exp_v = (q.size() > 0) ? q.pop_front() : 32'hxxxx_xxxx;
      chk("xfer_data", DataE, exp_v);
    end
    @(posedge Clk);
    if (Flush) q.delete();
    else if (acc) q.push_back(DataD);
    if (inc) begin
      stall_exp++;
      if (stall_small_exp < 7) stall_small_exp++;
    end
    #1;
  endtask

  initial begin
    Rst = 1'b1; ValidD = 1'b0; DataD = '0; ReadyE = 1'b0; Flush = 1'b0;
    #12;
    chk("rst_valid_e", ValidE, 0);
    chk("rst_data_e", DataE, 0);
    chk("rst_stall", StallCount, 0);
    @(negedge Clk); Rst = 1'b0;
    #1 chk("ready_after_rst", ReadyD, 1);
    @(posedge Clk); #1;

    // Full-rate stream, then a gap and one more beat.
    ReadyE = 1'b1; ValidD = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      DataD = i;
      #0 chk("stream_ready", ReadyD, 1);
      tick();
    end
    ValidD = 1'b0; tick();
    ValidD = 1'b1; DataD = 32'h4; tick();
    ValidD = 1'b0; tick(); tick();

    // Five-cycle stall on one beat.
    ReadyE = 1'b0; ValidD = 1'b1; DataD = 32'hA5A5; tick();
    ValidD = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_five", StallCount, 5);
    chk("stall_hold", DataE, 32'hA5A5);
    ReadyE = 1'b1; tick(); tick();

    // Flush with a simultaneous transfer and incoming beat 0x77.
    ReadyE = 1'b0; ValidD = 1'b1; DataD = 32'h55; tick();
    ReadyE = 1'b1; DataD = 32'h77; Flush = 1'b1; tick();
    Flush = 1'b0; ValidD = 1'b0;
    chk("flush_valid", ValidE, 0);
    chk("flush_data", DataE, 0);
    tick(); tick();

    // Flush during back-pressure must not count as a stall cycle.
    ReadyE = 1'b0; ValidD = 1'b1; DataD = 32'h66; tick();
    ValidD = 1'b0; Flush = 1'b1; tick();
    Flush = 1'b0; tick();
    chk("flush_no_stall", StallCount, 5);

    // Long back-pressure: small counter saturates at 7.
    ValidD = 1'b1; DataD = 32'h99; tick();
    ValidD = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_small", s_StallCount, 7);
    chk("count_wide", StallCount, 15);
    ReadyE = 1'b1; tick(); tick();

    // Two beats under back-pressure, then release.
    ReadyE = 1'b0; ValidD = 1'b1; DataD = 32'h10; tick();
    DataD = 32'h20;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    chk("skid_ready_one", ReadyD, 1);
    tick();
    chk("skid_ready_full", ReadyD, 0);
    ReadyE = 1'b1;
    #1 chk("skid_ready_registered", ReadyD, 0);
`else
    chk("base_ready_stall", ReadyD, 0);
    tick();
    ReadyE = 1'b1;
    #1 chk("base_ready_comb", ReadyD, 1);
`endif
    tick();
    ValidD = 1'b0;
    tick(); tick(); tick();

    // Asynchronous reset mid-stream.
    ReadyE = 1'b0; ValidD = 1'b1; DataD = 32'hDEADBEEF; tick();
    ValidD = 1'b0;
    chk("pre_rst_data", DataE, 32'hDEADBEEF);
    #2 Rst = 1'b1;
    #1;
    chk("async_rst_valid", ValidE, 0);
    chk("async_rst_data", DataE, 0);
    chk("async_rst_stall", StallCount, 0);
    chk("async_rst_stall_small", s_StallCount, 0);
    q.delete(); stall_exp = 0; stall_small_exp = 0;
    @(negedge Clk); Rst = 1'b0;
    @(posedge Clk); #1;
    ReadyE = 1'b1; ValidD = 1'b1; DataD = 32'hC; tick();
    ValidD = 1'b0; tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
